// File: rtl/fnd_scan_ctrl.sv
// 4-digit multiplexed FND scan controller: binary-to-BCD conversion (double dabble)
// feeding a display register, scanned one digit per prescaler tick with leading-zero blanking.
module fnd_scan_ctrl #(
   parameter int unsigned P_SCAN_DIV = 100000
) (
   input  logic        i_clk,
   input  logic        i_Reset,
   input  logic [13:0] i_Value,
   input  logic        i_Load,
   input  logic        i_Blank_Lz,
   output logic        o_Busy,
   output logic        o_Done,
   output logic [3:0]  o_BCD,
   output logic        o_En,
   output logic [3:0]  o_Digit_Sel
);

   localparam int unsigned W_VAL   = 14;
   localparam int unsigned W_BCD   = 16;
   localparam int unsigned W_CNT   = 4;
   localparam int unsigned N_ITER  = 14;
   localparam int unsigned W_PRESC = (P_SCAN_DIV > 1) ? $clog2(P_SCAN_DIV) : 1;

   localparam logic [W_VAL-1:0]   C_MAX_VAL    = W_VAL'(9999);
   localparam logic [W_CNT-1:0]   C_LAST_ITER  = W_CNT'(N_ITER - 1);
   localparam logic [W_PRESC-1:0] C_PRESC_LAST = W_PRESC'(P_SCAN_DIV - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_capture;
   logic               w_shift;
   logic               w_commit;
   logic               w_busy_nxt;

   logic [W_VAL-1:0]   r_bin;
   logic [W_BCD-1:0]   r_bcd;
   logic [W_BCD-1:0]   w_bcd_adj;
   logic [W_CNT-1:0]   r_cnt;
   logic [W_BCD-1:0]   r_disp;

   logic [W_PRESC-1:0] r_presc;
   logic [1:0]         r_idx;
   logic [1:0]         w_idx_nxt;
   logic               w_tick;
   logic [3:0]         w_sel_nxt;
   logic [3:0]         w_bcd_nxt;
   logic               w_hi_zero;
   logic               w_en_nxt;

   // Converter state register
   always_ff @(posedge i_clk) begin
      if (i_Reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Converter next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_Load) w_state_nxt = S_SHIFT;
         S_SHIFT: if (r_cnt == C_LAST_ITER) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Converter control decode; busy/done are registered from these in the datapath
   always_comb begin
      w_capture = 1'b0;
      w_shift   = 1'b0;
      w_commit  = 1'b0;
      case (r_state)
         S_IDLE:  w_capture = i_Load;
         S_SHIFT: w_shift   = 1'b1;
         S_DONE:  w_commit  = 1'b1;
         default: ;
      endcase
      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   // Double-dabble correction: +3 on every nibble >= 5 before the shift
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < 4; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_Reset) begin
         r_bin  <= '0;
         r_bcd  <= '0;
         r_cnt  <= '0;
         r_disp <= '0;
         o_Busy <= 1'b0;
         o_Done <= 1'b0;
      end else begin
         o_Busy <= w_busy_nxt;
         o_Done <= w_commit;
         if (w_capture) begin
            r_bin <= (i_Value > C_MAX_VAL) ? C_MAX_VAL : i_Value;
            r_bcd <= '0;
            r_cnt <= '0;
         end
         if (w_shift) begin
            r_bcd <= {w_bcd_adj[W_BCD-2:0], r_bin[W_VAL-1]};
            r_bin <= {r_bin[W_VAL-2:0], 1'b0};
            r_cnt <= r_cnt + W_CNT'(1);
         end
         if (w_commit) r_disp <= r_bcd;
      end
   end

   // Scan outputs for the slot that becomes active on the next tick
   always_comb begin
      w_tick    = (r_presc == C_PRESC_LAST);
      w_idx_nxt = r_idx + 2'd1;
      w_sel_nxt = ~(4'b0001 << w_idx_nxt);
      w_bcd_nxt = r_disp[{w_idx_nxt, 2'b00} +: 4];
      case (w_idx_nxt)
         2'd1:    w_hi_zero = (r_disp[15:4]  == 12'd0);
         2'd2:    w_hi_zero = (r_disp[15:8]  == 8'd0);
         2'd3:    w_hi_zero = (r_disp[15:12] == 4'd0);
         default: w_hi_zero = 1'b0;
      endcase
      w_en_nxt = !(i_Blank_Lz && w_hi_zero);
   end

   always_ff @(posedge i_clk) begin
      if (i_Reset) begin
         r_presc     <= '0;
         r_idx       <= 2'd0;
         o_BCD       <= 4'd0;
         o_En        <= 1'b1;
         o_Digit_Sel <= 4'b1110;
      end else if (w_tick) begin
         r_presc     <= '0;
         r_idx       <= w_idx_nxt;
         o_BCD       <= w_bcd_nxt;
         o_En        <= w_en_nxt;
         o_Digit_Sel <= w_sel_nxt;
      end else begin
         r_presc <= r_presc + W_PRESC'(1);
      end
   end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl with a 4-cycle scan slot: table of conversions checked through
// a scoreboard on o_Done, scan-slot contents, tick spacing, ignored loads and reset abort.
module tb_fnd_scan_ctrl;

   logic        clk = 1'b0;
   logic        i_Reset;
   logic [13:0] i_Value;
   logic        i_Load;
   logic        i_Blank_Lz;
   logic        o_Busy;
   logic        o_Done;
   logic [3:0]  o_BCD;
   logic        o_En;
   logic [3:0]  o_Digit_Sel;

   always #5 clk = ~clk;

   fnd_scan_ctrl #(.P_SCAN_DIV(4)) dut (
      .i_clk       (clk),
      .i_Reset     (i_Reset),
      .i_Value     (i_Value),
      .i_Load      (i_Load),
      .i_Blank_Lz  (i_Blank_Lz),
      .o_Busy      (o_Busy),
      .o_Done      (o_Done),
      .o_BCD       (o_BCD),
      .o_En        (o_En),
      .o_Digit_Sel (o_Digit_Sel)
   );

   typedef struct {
      logic [13:0] value;
      logic        blank;
      logic [15:0] exp_disp;
      logic [3:0]  exp_en;
   } vec_t;

   vec_t vecs[10];
   vec_t sb_q[$];

   int         n_chk  = 0;
   int         n_fail = 0;
   int         mon_cnt = 0;
   logic [1:0] mon_idx = 2'd0;
   logic [3:0] mon_prev = 4'b1110;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock; sample at negedge and track digit-select rotation and tick spacing
   task automatic tick_cycle();
      logic [1:0] nidx;
      logic [3:0] exp_sel;
      @(negedge clk);
      if (i_Reset) begin
         chk("sel_after_reset", 32'(o_Digit_Sel), 32'h0000000e);
         mon_cnt  = 0;
         mon_idx  = 2'd0;
         mon_prev = 4'b1110;
      end else begin
         mon_cnt++;
         if (o_Digit_Sel !== mon_prev) begin
            nidx    = mon_idx + 2'd1;
            exp_sel = ~(4'b0001 << nidx);
            chk("tick_spacing", 32'(mon_cnt), 32'd4);
            chk("sel_rotation", 32'(o_Digit_Sel), 32'(exp_sel));
            mon_idx  = nidx;
            mon_prev = o_Digit_Sel;
            mon_cnt  = 0;
         end else if (mon_cnt > 4) begin
            chk("missed_tick", 32'(mon_cnt), 32'd4);
            mon_cnt = 0;
         end
      end
   endtask

   // Watch five ticks: each slot shows the expected digit/enable; nothing changes before the first tick
   task automatic check_slots(input vec_t e);
      logic [3:0]  hold_bcd;
      logic [3:0]  prev_sel;
      logic [15:0] tmp;
      int          slot;
      int          changes;
      int          extra_done;
      hold_bcd   = o_BCD;
      prev_sel   = o_Digit_Sel;
      changes    = 0;
      extra_done = 0;
      for (int cyc = 0; cyc < 30 && changes < 5; cyc++) begin
         tick_cycle();
         if (o_Done) extra_done++;
         if (o_Digit_Sel !== prev_sel) begin
            changes++;
            case (o_Digit_Sel)
               4'b1101: slot = 1;
               4'b1011: slot = 2;
               4'b0111: slot = 3;
               default: slot = 0;
            endcase
            tmp = e.exp_disp >> (4 * slot);
            chk($sformatf("bcd_slot%0d_val%0d", slot, e.value), 32'(o_BCD), 32'(tmp[3:0]));
            chk($sformatf("en_slot%0d_val%0d", slot, e.value), 32'(o_En), 32'(e.exp_en[slot]));
            prev_sel = o_Digit_Sel;
         end else if (changes == 0) begin
            chk("bcd_hold_until_tick", 32'(o_BCD), 32'(hold_bcd));
         end
      end
      chk("slot_ticks_seen", 32'(changes), 32'd5);
      chk("no_extra_done", 32'(extra_done), 32'd0);
      chk("idle_after_result", 32'(o_Busy), 32'd0);
   endtask

   // Issue a load (optionally re-pulsing i_Load at given cycles) and check the result via the scoreboard
   task automatic run_load(input vec_t v, input int relo_a, input int relo_b);
      vec_t e;
      int   busy_cnt;
      int   done_cyc;
      i_Blank_Lz = v.blank;
      i_Value    = v.value;
      i_Load     = 1'b1;
      sb_q.push_back(v);
      busy_cnt = 0;
      done_cyc = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         tick_cycle();
         i_Load = (cyc == relo_a) || (cyc == relo_b);
         if (o_Busy) busy_cnt++;
         if (o_Done) begin
            done_cyc = cyc;
            break;
         end
      end
      i_Load = 1'b0;
      chk("done_latency", 32'(done_cyc), 32'd16);
      chk("busy_cycles", 32'(busy_cnt), 32'd15);
      chk("busy_low_at_done", 32'(o_Busy), 32'd0);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         if (done_cyc != 0) check_slots(e);
      end
   endtask

   initial begin
      vec_t zero_v;
      vec_t v;
      int   dones;

      vecs[0] = '{14'd1234,  1'b0, 16'h1234, 4'b1111};
      vecs[1] = '{14'd7,     1'b1, 16'h0007, 4'b0001};
      vecs[2] = '{14'd7,     1'b0, 16'h0007, 4'b1111};
      vecs[3] = '{14'd1005,  1'b1, 16'h1005, 4'b1111};
      vecs[4] = '{14'd0,     1'b1, 16'h0000, 4'b0001};
      vecs[5] = '{14'd50,    1'b1, 16'h0050, 4'b0011};
      vecs[6] = '{14'd9999,  1'b1, 16'h9999, 4'b1111};
      vecs[7] = '{14'd10000, 1'b1, 16'h9999, 4'b1111};
      vecs[8] = '{14'd0,     1'b0, 16'h0000, 4'b1111};
      vecs[9] = '{14'd908,   1'b1, 16'h0908, 4'b0111};
      zero_v  = '{14'd0,     1'b0, 16'h0000, 4'b1111};

      i_Reset    = 1'b1;
      i_Value    = '0;
      i_Load     = 1'b0;
      i_Blank_Lz = 1'b0;
      tick_cycle();
      tick_cycle();
      i_Reset = 1'b0;
      chk("rst_busy", 32'(o_Busy), 32'd0);
      chk("rst_done", 32'(o_Done), 32'd0);
      chk("rst_bcd",  32'(o_BCD),  32'd0);
      chk("rst_en",   32'(o_En),   32'd1);
      chk("rst_sel",  32'(o_Digit_Sel), 32'he);

      for (int i = 0; i < 10; i++) run_load(vecs[i], -1, -1);

      // Saturating value with extra loads at load+5 and during DONE: only one result
      v = '{14'h3FFF, 1'b0, 16'h9999, 4'b1111};
      run_load(v, 5, 15);

      // Reset at load+8 aborts the conversion; display stays zero
      i_Blank_Lz = 1'b0;
      i_Value    = 14'd4321;
      i_Load     = 1'b1;
      dones      = 0;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         tick_cycle();
         i_Load = 1'b0;
         if (o_Done) dones++;
         if (cyc == 8) i_Reset = 1'b1;
      end
      tick_cycle();
      i_Reset = 1'b0;
      chk("abort_no_done", 32'(dones), 32'd0);
      chk("abort_busy", 32'(o_Busy), 32'd0);
      chk("abort_done", 32'(o_Done), 32'd0);
      chk("abort_bcd",  32'(o_BCD),  32'd0);
      chk("abort_en",   32'(o_En),   32'd1);
      chk("abort_sel",  32'(o_Digit_Sel), 32'he);
      check_slots(zero_v);

      // Reset wins over a simultaneous load
      i_Reset = 1'b1;
      i_Load  = 1'b1;
      i_Value = 14'd55;
      tick_cycle();
      i_Reset = 1'b0;
      i_Load  = 1'b0;
      chk("rst_over_load_busy", 32'(o_Busy), 32'd0);
      check_slots(zero_v);

      v = '{14'd4321, 1'b1, 16'h4321, 4'b1111};
      run_load(v, -1, -1);

      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
